// File: rtl/lc4_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
// The optional ovf/zero flag outputs are enabled by defining LC4_CLA_PIPE_FLAGS_EN.
module lc4_cla_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef LC4_CLA_PIPE_FLAGS_EN
  ,
  output logic         ovf,
  output logic         zero
`endif
);

  localparam int SW = W / STAGES;  // bits per stage
  localparam int NG = SW / 4;      // lookahead groups per stage
  localparam int L  = STAGES - 1;

  // Adds one stage slice; returns {carry out, sum}.
  // Groups use 4-bit lookahead internally, and group carries ripple via (G, P).
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [3:0]    g, p, c;
    logic          gg, gp, gc;
    logic [SW-1:0] s;
    // NOTE: combinational code (functions, always_comb) uses blocking '='
    // so each line sees the value computed on the line above.
    gc = ci;
    s  = '0;
    for (int j = 0; j < NG; j++) begin
      g    = x[4*j +: 4] & y[4*j +: 4];
      p    = x[4*j +: 4] | y[4*j +: 4];
      c[0] = gc;
      c[1] = g[0] | (p[0] & gc);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & gc);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      gp   = &p;
      s[4*j +: 4] = x[4*j +: 4] ^ y[4*j +: 4] ^ c;
      gc   = gg | (gp & gc);
    end
    return {gc, s};
  endfunction

  logic [W-1:0]      b_eff;
  logic              c0;
  logic [STAGES-1:0] vld;  // stage holds an operation
  logic [STAGES-1:0] acc;  // stage register may load this cycle

  assign b_eff = b ^ {W{sub}};
  assign c0    = cin ^ sub;

  // A stage can load when it is empty or its content moves on; this lets
  // bubbles collapse while the output is stalled.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // leaves it unassigned and infers a latch.
    acc    = '0;
    acc[L] = !vld[L] | out_ready;
    for (int k = L - 1; k >= 0; k--) acc[k] = !vld[k] | acc[k+1];
  end

  assign in_ready = acc[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]       x, y;
    logic                ci;
    logic                up_v;
    logic [SW:0]         r;
    logic [(k+1)*SW-1:0] nxt_sum;
    logic                vld_q;
    logic [(k+1)*SW-1:0] sum_q;    // low bits finished so far
    logic                carry_q;  // carry into the next slice (cout in the last stage)

    if (k == 0) begin : g_src
      assign x       = a[SW-1:0];
      assign y       = b_eff[SW-1:0];
      assign ci      = c0;
      assign up_v    = in_valid;
      assign r       = slice_add(x, y, ci);
      assign nxt_sum = r[SW-1:0];
    end else begin : g_src
      assign x       = g_stage[k-1].g_ops.opa_q[SW-1:0];
      assign y       = g_stage[k-1].g_ops.opb_q[SW-1:0];
      assign ci      = g_stage[k-1].carry_q;
      assign up_v    = vld[k-1];
      assign r       = slice_add(x, y, ci);
      assign nxt_sum = {r[SW-1:0], g_stage[k-1].sum_q};
    end

    assign vld[k] = vld_q;

    always_ff @(posedge clk) begin
      if (rst)         vld_q <= 1'b0;
      else if (acc[k]) vld_q <= up_v;
    end

    if (k < L) begin : g_ops
      localparam int REM = W - (k + 1) * SW;
      logic [REM-1:0] nxt_a, nxt_b;
      logic [REM-1:0] opa_q, opb_q;  // operand slices still to be added

      if (k == 0) begin : g_rem
        assign nxt_a = a[W-1:SW];
        assign nxt_b = b_eff[W-1:SW];
      end else begin : g_rem
        assign nxt_a = g_stage[k-1].g_ops.opa_q[REM+SW-1:SW];
        assign nxt_b = g_stage[k-1].g_ops.opb_q[REM+SW-1:SW];
      end

      // NOTE: intermediate data registers carry no reset; the cleared valid
      // bit is what discards them, and only the visible outputs are reset.
      always_ff @(posedge clk) begin
        if (acc[k] && up_v) begin
          sum_q   <= nxt_sum;
          carry_q <= r[SW];
          opa_q   <= nxt_a;
          opb_q   <= nxt_b;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q   <= '0;
          carry_q <= 1'b0;
        end else if (acc[k] && up_v) begin
          sum_q   <= nxt_sum;
          carry_q <= r[SW];
        end
      end

`ifdef LC4_CLA_PIPE_FLAGS_EN
      // Carry into the MSB is recovered from the MSB sum and operand bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (acc[k] && up_v) begin
          ovf  <= (x[SW-1] ^ y[SW-1] ^ r[SW-1]) ^ r[SW];
          zero <= (nxt_sum == '0);
        end
      end
`endif
    end
  end

  assign out_valid = vld[L];
  assign sum       = g_stage[L].sum_q;
  assign cout      = g_stage[L].carry_q;

endmodule

// File: tb/tb_lc4_cla_pipe.sv
// Self-checking bench for lc4_cla_pipe (W=16, STAGES=2): directed vectors,
// back-to-back streaming, back-pressure and reset in flight.
module tb_lc4_cla_pipe;
  localparam int W      = 16;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef LC4_CLA_PIPE_FLAGS_EN
  logic         ovf, zero;
`endif

  int tests = 0;
  int fails = 0;

  lc4_cla_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef LC4_CLA_PIPE_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic sv, input logic cv);
    logic [W:0] be;
    be = sv ? {1'b0, ~bv} : {1'b0, bv};
    return {1'b0, av} + be + {{W{1'b0}}, cv ^ sv};
  endfunction

  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic sv, input logic cv, input logic [W-1:0] es,
                    input logic ec, input logic ez, input logic eo);
    int n = 0;
    a = av; b = bv; sub = sv; cin = cv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, STAGES - 1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
`ifdef LC4_CLA_PIPE_FLAGS_EN
    check({tag, ".zero"}, zero, ez);
    check({tag, ".ovf"}, ovf, eo);
`else
    if (ez === 1'bx || eo === 1'bx) check({tag, ".flag_args"}, 0, 1);
`endif
  endtask

  logic [W-1:0] sa [8];
  logic [W-1:0] sb [8];
  logic         ss [8];
  logic         sc [8];

  // Streams n ops; out_ready is held low for the first 'stall' cycles.
  task automatic stream(input string tag, input int n, input int stall);
    logic [W:0] q[$];
    logic [W:0] e;
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1, acc_stall = 0;
    logic rdy_at_stall_end = 1'b1;
    while (got < n && cyc < 100) begin
      out_ready = (cyc >= stall);
      if (sent < n) begin
        in_valid = 1'b1;
        a = sa[sent]; b = sb[sent]; sub = ss[sent]; cin = sc[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == stall - 1) rdy_at_stall_end = in_ready;
      if (out_valid && !out_ready) begin
        if (q.size() == 0) check({tag, ".spurious"}, out_valid, 0);
        else               check({tag, ".hold"}, {cout, sum}, q[0]);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sub, cin));
        sent++;
        if (cyc < stall) acc_stall++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, ".spurious"}, out_valid, 0);
        end else begin
          e = q.pop_front();
          check({tag, ".result"}, {cout, sum}, e);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".count"}, got, n);
    check({tag, ".leftover"}, q.size(), 0);
    if (stall == 0) begin
      check({tag, ".consecutive"}, last - first, n - 1);
    end else begin
      check({tag, ".buffered"}, acc_stall, STAGES);
      check({tag, ".in_ready_stalled"}, rdy_at_stall_end, 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst.out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid_after", out_valid, 0);
    check("rst.sum", sum, 16'h0000);
    check("rst.cout", cout, 0);

    //       tag           a         b         sub   cin   sum       cout  zero  ovf
    op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    op("boundary", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    op("sub_brw",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    op("add_cin",  16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);
    op("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    op("all_ones", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom); sb[i] = W'($urandom);
      ss[i] = 1'($urandom); sc[i] = 1'($urandom);
    end
    stream("b2b", 8, 0);

    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom); sb[i] = W'($urandom);
      ss[i] = 1'($urandom); sc[i] = 1'($urandom);
    end
    stream("bp", 6, 5);
    out_ready = 1'b1;
    tick();

    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.sum", sum, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst.no_emit", out_valid, 0);
    end
    op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
